// File: rtl/prog_loader.sv
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Boot-time loader. It takes a length-prefixed byte stream, writes
//             the stream into memory from address 0, and holds the CPU in
//             reset until the image checksum has verified.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              restart_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [15:0] c_max_len = 16'(MEM_DEPTH);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [DATA_W-1:0] r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_count;
    logic [DATA_W-1:0] r_sum;
    logic              w_busy;
    logic              w_accept;
    logic              w_wr;
    logic [15:0]       w_len;

    assign w_len = {rx_data_i, r_len_lo};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (restart_i) begin
            w_next = S_LEN_LO;
        end else begin
            case (r_state)
                S_LEN_LO: if (w_accept) w_next = S_LEN_HI;
                S_LEN_HI: begin
                    if (w_accept) begin
                        if (w_len > c_max_len)  w_next = S_ERR;
                        else if (w_len == 16'd0) w_next = S_CSUM;
                        else                     w_next = S_DATA;
                    end
                end
                S_DATA:   if (w_accept && (r_count + 16'd1 == r_len)) w_next = S_CSUM;
                S_CSUM:   if (w_accept) w_next = (rx_data_i == r_sum) ? S_DONE : S_ERR;
                S_DONE:   w_next = S_DONE;
                S_ERR:    w_next = S_ERR;
                default:  w_next = S_LEN_LO;
            endcase
        end
    end

    // Output decode; ready drops combinationally while rst_i is asserted
    always_comb begin
        w_busy     = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
        rx_ready_o = w_busy && !rst_i;
        w_accept   = rx_valid_i && rx_ready_o;
        w_wr       = w_accept && (r_state == S_DATA) && !restart_i;
    end

    // Datapath and registered status; a byte seen in a restart cycle is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len_lo   <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            cpu_rst_o  <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            mem_we_o  <= w_wr;
            done_o    <= (w_next == S_DONE);
            err_o     <= (w_next == S_ERR);
            cpu_rst_o <= (w_next != S_DONE);
            if (restart_i) begin
                r_count <= '0;
                r_sum   <= '0;
            end else begin
                if (w_accept && (r_state == S_LEN_LO)) begin
                    r_len_lo <= rx_data_i;
                end
                if (w_accept && (r_state == S_LEN_HI)) begin
                    r_len <= w_len;
                end
                if (w_wr) begin
                    mem_addr_o <= r_count[ADDR_W-1:0];
                    mem_data_o <= rx_data_i;
                    r_count    <= r_count + 16'd1;
                    r_sum      <= r_sum + rx_data_i;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader using a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_i, restart_i, rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_ready_o, mem_we_o, cpu_rst_o, done_o, err_o;
    logic [7:0] mem_addr_o, mem_data_o;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .restart_i  (restart_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .cpu_rst_o  (cpu_rst_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Frame-level model: the accepted bytes since the last (re)start fully
    // determine the expected outputs for the following cycle.
    logic [7:0] q[$];
    bit         mdl_on = 1'b0;
    logic       exp_we, exp_done, exp_err, exp_cpu;
    logic [7:0] exp_addr, exp_data;
    int         n, flen, s;

    always @(posedge clk) begin
        exp_we = 1'b0;
        if (rst_i) begin
            q.delete();
            exp_addr = 8'd0; exp_data = 8'd0;
            exp_done = 1'b0; exp_err  = 1'b0; exp_cpu = 1'b1;
            mdl_on   = 1'b1;
        end else if (restart_i) begin
            q.delete();
            exp_done = 1'b0; exp_err = 1'b0; exp_cpu = 1'b1;
        end else if (rx_valid_i && !exp_done && !exp_err) begin
            q.push_back(rx_data_i);
            n    = q.size();
            flen = (n >= 2) ? (int'(q[1]) * 256 + int'(q[0])) : -1;
            if (n == 2 && flen > 256) begin
                exp_err = 1'b1;
            end else if (n >= 3 && n <= flen + 2) begin
                exp_we   = 1'b1;
                exp_addr = 8'(n - 3);
                exp_data = rx_data_i;
            end else if (n >= 3 && n == flen + 3) begin
                s = 0;
                for (int i = 2; i < n - 1; i++) s += int'(q[i]);
                if ((s % 256) == int'(q[n-1])) begin
                    exp_done = 1'b1; exp_cpu = 1'b0;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
    end

    logic [7:0] wlog_a[$];
    logic [7:0] wlog_d[$];

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("mem_we", mem_we_o, exp_we);
            if (exp_we) begin
                chk("mem_addr", mem_addr_o, exp_addr);
                chk("mem_data", mem_data_o, exp_data);
            end
            chk("done", done_o, exp_done);
            chk("err", err_o, exp_err);
            chk("cpu_rst", cpu_rst_o, exp_cpu);
            chk("rx_ready", rx_ready_o, !rst_i && !exp_done && !exp_err);
            if (mem_we_o === 1'b1) begin
                wlog_a.push_back(mem_addr_o);
                wlog_d.push_back(mem_data_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input int gapmax);
        repeat ($urandom_range(gapmax, 0)) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
            tick();
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] f[$], input int gapmax);
        foreach (f[i]) put(f[i], gapmax);
        repeat (2) tick();
    endtask

    task automatic do_restart();
        restart_i  = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'($urandom);
        tick();
        restart_i  = 1'b0;
        rx_valid_i = 1'b0;
        wlog_a.delete();
        wlog_d.delete();
    endtask

    task automatic chk_case1(input string nm);
        chk({nm, "_nwr"}, wlog_a.size(), 3);
        if (wlog_a.size() == 3) begin
            chk({nm, "_a0"}, wlog_a[0], 8'd0);  chk({nm, "_d0"}, wlog_d[0], 8'd10);
            chk({nm, "_a1"}, wlog_a[1], 8'd1);  chk({nm, "_d1"}, wlog_d[1], 8'd20);
            chk({nm, "_a2"}, wlog_a[2], 8'd2);  chk({nm, "_d2"}, wlog_d[2], 8'd30);
        end
        chk({nm, "_done"}, done_o, 1'b1);
        chk({nm, "_cpu"}, cpu_rst_o, 1'b0);
        chk({nm, "_ready"}, rx_ready_o, 1'b0);
    endtask

    logic [7:0] fr[$];
    int         rlen, mode;
    logic [7:0] csum;

    initial begin
        rst_i = 1'b1; restart_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'd0;
        tick(); tick();
        chk("rst_cpu", cpu_rst_o, 1'b1);
        chk("rst_done", done_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_addr", mem_addr_o, 8'd0);
        chk("rst_ready", rx_ready_o, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", rx_ready_o, 1'b1);
        wlog_a.delete(); wlog_d.delete();

        fr = '{8'd3, 8'd0, 8'd10, 8'd20, 8'd30, 8'd60};
        send(fr, 0);
        chk_case1("t1");

        do_restart();
        fr = '{8'd3, 8'd0, 8'd10, 8'd20, 8'd30, 8'd61};
        send(fr, 0);
        chk("t2_nwr", wlog_a.size(), 3);
        chk("t2_err", err_o, 1'b1);
        chk("t2_done", done_o, 1'b0);
        chk("t2_cpu", cpu_rst_o, 1'b1);

        do_restart();
        fr = '{8'h01, 8'h01};
        send(fr, 0);
        chk("t3_err", err_o, 1'b1);
        chk("t3_nwr", wlog_a.size(), 0);

        do_restart();
        fr = '{8'h00, 8'h00, 8'h00};
        send(fr, 0);
        chk("t4a_done", done_o, 1'b1);
        chk("t4a_nwr", wlog_a.size(), 0);

        do_restart();
        fr = '{8'h00, 8'h01};
        repeat (256) fr.push_back(8'hFF);
        fr.push_back(8'h00);
        send(fr, 0);
        chk("t4b_done", done_o, 1'b1);
        chk("t4b_nwr", wlog_a.size(), 256);
        if (wlog_a.size() == 256) begin
            chk("t4b_first", wlog_a[0], 8'h00);
            chk("t4b_last", wlog_a[255], 8'hFF);
        end

        do_restart();
        fr = '{8'd3, 8'd0, 8'd10, 8'd20, 8'd30, 8'd60};
        send(fr, 4);
        chk_case1("t5");

        do_restart();
        fr = '{8'd3, 8'd0, 8'd10, 8'd20};
        send(fr, 1);
        do_restart();
        fr = '{8'd3, 8'd0, 8'd10, 8'd20, 8'd30, 8'd60};
        send(fr, 2);
        chk_case1("t6");

        // Randomized frames with occasional aborts and trailing junk bytes
        for (int k = 0; k < 24; k++) begin
            do_restart();
            mode = $urandom_range(9, 0);
            case (mode)
                0:       rlen = 0;
                1:       rlen = 256;
                2:       rlen = 257 + $urandom_range(3000, 0);
                3:       rlen = 255;
                default: rlen = $urandom_range(40, 1);
            endcase
            fr.delete();
            fr.push_back(8'(rlen));
            fr.push_back(8'(rlen >> 8));
            csum = 8'd0;
            if (rlen <= 256) begin
                for (int i = 0; i < rlen; i++) begin
                    fr.push_back(8'($urandom));
                    csum = csum + fr[fr.size()-1];
                end
                fr.push_back(($urandom_range(3, 0) == 0) ? csum + 8'd1 : csum);
            end
            fr.push_back(8'($urandom));
            if ($urandom_range(5, 0) == 0 && fr.size() > 4) begin
                for (int i = 0; i < 4; i++) put(fr[i], 2);
                if ($urandom_range(1, 0) == 1) begin
                    rst_i = 1'b1; tick(); rst_i = 1'b0;
                end else begin
                    do_restart();
                end
            end
            send(fr, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
